mult_sched: RTL and testbench

- Sequencer and arbiter for the 8-bit signed shift-add multiplier datapath (A/X/B registers, 9-bit add/sub, shift chain).
- Accepts multiply jobs from two requesters over valid/ready handshakes and grants one at a time, round-robin.
- Drives the datapath control strobes and operand bus directly, with no button synchronisers in the path.
- Returns the 16-bit product {A,B} and the requester ID over a valid/ready response channel.

---
 rtl/mult_sched_pkg.sv | 27 ++
 rtl/mult_sched_if.sv | 62 ++++++
 rtl/mult_sched_rr_arb2.sv | 59 +++++
 rtl/mult_sched.sv | 159 +++++++++++++++
 tb/tb_mult_sched.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_sched_pkg
//  Description : Shared types and constants for the shift-add multiplier
//                sequencer: FSM state encoding, operand width, iteration
//                count and the fixed accept-to-response latency.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_sched_pkg;

    localparam int WIDTH   = 8;                 // operand width, matches datapath
    localparam int ITER    = 8;                 // add/shift pairs per job, equals WIDTH
    localparam int LATENCY = 19;                // accept cycle to first resp_valid cycle
    localparam int CNT_W   = $clog2(ITER);      // iteration counter width

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4,
        RESP  = 3'd5
    } sched_state_t;

endpackage : mult_sched_pkg
`default_nettype wire

// File: rtl/mult_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_sched_if
//  Description : Bundle of the request, response and datapath-control
//                signals of the multiplier sequencer.
//  Ports       : req_valid/req_ready/req_mand*/req_mult*  job requests (x2)
//                resp_valid/resp_ready/resp_id/resp_prod   product return
//                busy                                      sequencer active
//                dp_*                                      datapath control/status
//  Modports    : slave  - the sequencer (mult_sched)
//                master - requesters, consumer and datapath around it
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_sched_if;
    import mult_sched_pkg::*;

    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [WIDTH-1:0]   req_mand0;
    logic [WIDTH-1:0]   req_mand1;
    logic [WIDTH-1:0]   req_mult0;
    logic [WIDTH-1:0]   req_mult1;

    logic               resp_valid;
    logic               resp_ready;
    logic               resp_id;
    logic [2*WIDTH-1:0] resp_prod;

    logic               busy;

    logic [WIDTH-1:0]   dp_mand;
    logic               dp_clr_ld;
    logic               dp_clearA;
    logic               dp_addsub;
    logic               dp_sub_en;
    logic               dp_shift_en;
    logic               dp_bout;
    logic [WIDTH-1:0]   dp_aval;
    logic [WIDTH-1:0]   dp_bval;

    modport slave (
        input  req_valid, req_mand0, req_mand1, req_mult0, req_mult1,
        output req_ready,
        output resp_valid, resp_id, resp_prod,
        input  resp_ready,
        output busy,
        output dp_mand, dp_clr_ld, dp_clearA, dp_addsub, dp_sub_en, dp_shift_en,
        input  dp_bout, dp_aval, dp_bval
    );

    modport master (
        output req_valid, req_mand0, req_mand1, req_mult0, req_mult1,
        input  req_ready,
        input  resp_valid, resp_id, resp_prod,
        output resp_ready,
        input  busy,
        input  dp_mand, dp_clr_ld, dp_clearA, dp_addsub, dp_sub_en, dp_shift_en,
        output dp_bout, dp_aval, dp_bval
    );

endinterface : mult_sched_if
`default_nettype wire

// File: rtl/mult_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter. A lone requester always wins;
//                when both request, rr_ptr picks the winner. After a grant
//                is consumed (advance) the pointer moves to the other side.
//  Ports       : Clk, Reset     clock, synchronous active-high reset
//                req[1:0]       request vector
//                advance        grant was consumed this cycle
//                grant[1:0]     one-hot grant, zero when no request
//                gnt_id         index of the granted requester
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       gnt_id
);

    logic rr_ptr_q;

    always_comb begin
        grant  = 2'b00;
        gnt_id = 1'b0;
        case (req)
            2'b01: begin
                grant  = 2'b01;
                gnt_id = 1'b0;
            end
            2'b10: begin
                grant  = 2'b10;
                gnt_id = 1'b1;
            end
            2'b11: begin
                gnt_id = rr_ptr_q;
                grant  = rr_ptr_q ? 2'b10 : 2'b01;
            end
            default: begin
                grant  = 2'b00;
                gnt_id = 1'b0;
            end
        endcase
    end

    // The pointer always lands on the side that did not just win, so a
    // requester that keeps asserting valid gets every other job.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rr_ptr_q <= 1'b0;
        end else if (advance) begin
            rr_ptr_q <= ~gnt_id;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mult_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mult_sched
//  Description : Sequencer and arbiter for the 8-bit signed shift-add
//                multiplier datapath. Accepts jobs from two requesters,
//                runs LOAD, eight ADD/SHIFT pairs and DONE, then returns
//                {A,B} and the requester ID on a valid/ready channel.
//  Ports       : Clk, Reset   clock, synchronous active-high reset
//                bus          mult_sched_if.slave: requests, response,
//                             busy, datapath strobes/operand and status
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_sched
    import mult_sched_pkg::*;
(
    input  logic         Clk,
    input  logic         Reset,
    mult_sched_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    sched_state_t        state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    mand_q, mand_d;
    logic [WIDTH-1:0]    mult_q, mult_d;
    logic                id_q, id_d;
    logic [2*WIDTH-1:0]  prod_q, prod_d;
    logic                resp_id_q, resp_id_d;

    logic [1:0]          arb_req;
    logic [1:0]          grant;
    logic                gnt_id;
    logic                accept;

    logic [WIDTH-1:0]    dp_mand;
    logic                clr_ld;
    logic                clear_a;
    logic                addsub;
    logic                sub_en;
    logic                shift_en;
    logic                resp_valid;

    // Requests are only presented to the arbiter while idle, so grant (and
    // therefore req_ready) is zero in every other state.
    assign arb_req = (state_q == IDLE) ? bus.req_valid : 2'b00;
    assign accept  = |(bus.req_valid & grant);

    rr_arb2 u_arb (
        .Clk     (Clk),
        .Reset   (Reset),
        .req     (arb_req),
        .advance (accept),
        .grant   (grant),
        .gnt_id  (gnt_id)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mand_d     = mand_q;
        mult_d     = mult_q;
        id_d       = id_q;
        prod_d     = prod_q;
        resp_id_d  = resp_id_q;
        dp_mand    = '0;
        clr_ld     = 1'b0;
        clear_a    = 1'b0;
        addsub     = 1'b0;
        sub_en     = 1'b0;
        shift_en   = 1'b0;
        resp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    mand_d  = gnt_id ? bus.req_mand1 : bus.req_mand0;
                    mult_d  = gnt_id ? bus.req_mult1 : bus.req_mult0;
                    id_d    = gnt_id;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // Multiplier goes into B; A and X start from zero.
                dp_mand = mult_q;
                clr_ld  = 1'b1;
                clear_a = 1'b1;
                cnt_d   = '0;
                state_d = ADD;
            end
            ADD: begin
                // The ADD slot is spent even when B[0]=0 so latency never
                // depends on the operand. The last bit carries negative
                // weight in two's complement, hence the subtract.
                dp_mand = mand_q;
                addsub  = bus.dp_bout;
                sub_en  = (cnt_q == LAST_CNT);
                state_d = SHIFT;
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ADD;
                end
            end
            DONE: begin
                prod_d    = {bus.dp_aval, bus.dp_bval};
                resp_id_d = id_q;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mand_q    <= '0;
            mult_q    <= '0;
            id_q      <= 1'b0;
            prod_q    <= '0;
            resp_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mand_q    <= mand_d;
            mult_q    <= mult_d;
            id_q      <= id_d;
            prod_q    <= prod_d;
            resp_id_q <= resp_id_d;
        end
    end

    assign bus.req_ready   = grant;
    assign bus.resp_valid  = resp_valid;
    assign bus.resp_id     = resp_id_q;
    assign bus.resp_prod   = prod_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.dp_mand     = dp_mand;
    assign bus.dp_clr_ld   = clr_ld;
    assign bus.dp_clearA   = clear_a;
    assign bus.dp_addsub   = addsub;
    assign bus.dp_sub_en   = sub_en;
    assign bus.dp_shift_en = shift_en;

endmodule : mult_sched
`default_nettype wire

// File: tb/tb_mult_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_mult_sched
//  Description : Bench for mult_sched. Contains a behavioural model of the
//                A/X/B datapath, a job-timeline model of the expected strobe
//                pattern, and a product scoreboard fed at accept time.
//  Ports       : none
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_sched;
    import mult_sched_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    mult_sched_if bus ();

    mult_sched dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // ---------------- datapath model: X:A:B with 9-bit add/sub ----------------
    logic [7:0] dpA = 8'h00;
    logic [7:0] dpB = 8'h00;
    logic       dpX = 1'b0;
    logic [8:0] dp_sum;

    assign bus.dp_bout = dpB[0];
    assign bus.dp_aval = dpA;
    assign bus.dp_bval = dpB;

    always @(posedge Clk) begin
        dp_sum = bus.dp_sub_en ? ({dpX, dpA} - {bus.dp_mand[7], bus.dp_mand})
                               : ({dpX, dpA} + {bus.dp_mand[7], bus.dp_mand});
        if (bus.dp_clr_ld) begin
            dpA <= 8'h00; dpX <= 1'b0; dpB <= bus.dp_mand;
        end else if (bus.dp_clearA) begin
            dpA <= 8'h00; dpX <= 1'b0;
        end else if (bus.dp_addsub) begin
            dpX <= dp_sum[8]; dpA <= dp_sum[7:0];
        end else if (bus.dp_shift_en) begin
            dpA <= {dpX, dpA[7:1]}; dpB <= {dpA[0], dpB[7:1]};
        end
    end

    // ---------------- bookkeeping ----------------
    int          checks   = 0;
    int          failures = 0;
    int          job_cyc  = -1;     // cycle index within current job, -1 = idle
    logic        tb_rr    = 1'b0;
    logic [7:0]  cur_mand = 8'h00;
    logic [7:0]  cur_mult = 8'h00;
    logic [15:0] hold_prod = 16'h0;
    logic        hold_id   = 1'b0;
    logic        post_reset = 1'b0;
    int          acc_cnt  = 0;
    int          resp_cnt = 0;
    int          acc_by [2] = '{0, 0};
    logic [16:0] sb [$];
    logic        rid_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event t=%0t", name, $time);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [1:0]  m_eg;
    logic        m_g;
    logic        m_add, m_shift;
    logic [7:0]  m_mand, m_mult;
    logic [16:0] m_exp;
    int          m_p;

    always @(negedge Clk) begin
        if (Reset) begin
            job_cyc    = -1;
            tb_rr      = 1'b0;
            post_reset = 1'b1;
            sb.delete();
        end else begin
            m_eg = 2'b00;
            m_g  = 1'b0;
            if (job_cyc < 0) begin
                case (bus.req_valid)
                    2'b01:   begin m_eg = 2'b01; m_g = 1'b0; end
                    2'b10:   begin m_eg = 2'b10; m_g = 1'b1; end
                    2'b11:   begin m_g = tb_rr; m_eg = tb_rr ? 2'b10 : 2'b01; end
                    default: begin m_eg = 2'b00; m_g = 1'b0; end
                endcase
            end
            m_add   = (job_cyc >= 2) && (job_cyc <= 16) && (job_cyc % 2 == 0);
            m_shift = (job_cyc >= 3) && (job_cyc <= 17) && (job_cyc % 2 == 1);

            chk("req_ready",   bus.req_ready,   m_eg);
            chk("busy",        bus.busy,        job_cyc >= 0);
            chk("dp_clr_ld",   bus.dp_clr_ld,   job_cyc == 1);
            chk("dp_clearA",   bus.dp_clearA,   job_cyc == 1);
            chk("dp_addsub",   bus.dp_addsub,   m_add & bus.dp_bout);
            chk("dp_sub_en",   bus.dp_sub_en,   job_cyc == 16);
            chk("dp_shift_en", bus.dp_shift_en, m_shift);
            chk("resp_valid",  bus.resp_valid,  job_cyc >= LATENCY);
            chk("strobe_excl", $countones({bus.dp_clr_ld, bus.dp_addsub, bus.dp_shift_en}) <= 1, 1);
            if (job_cyc == 1) chk("dp_mand_load", bus.dp_mand, cur_mult);
            if (m_add)        chk("dp_mand_add",  bus.dp_mand, cur_mand);
            if (job_cyc >= 0 && cur_mult == 8'h00) chk("addsub_zero_mult", bus.dp_addsub, 0);
            if (post_reset) begin
                chk("rst_resp_prod", bus.resp_prod, 0);
                chk("rst_resp_id",   bus.resp_id,   0);
                chk("rst_dp_mand",   bus.dp_mand,   0);
                post_reset = 1'b0;
            end

            if (job_cyc >= LATENCY) begin
                if (job_cyc == LATENCY) begin
                    hold_prod = bus.resp_prod;
                    hold_id   = bus.resp_id;
                end else begin
                    chk("hold_prod", bus.resp_prod, hold_prod);
                    chk("hold_id",   bus.resp_id,   hold_id);
                end
                if (bus.resp_ready) begin
                    if (sb.size() == 0) begin
                        timeout_fail("scoreboard_empty");
                    end else begin
                        m_exp = sb.pop_front();
                        chk("resp_id",   bus.resp_id,   m_exp[16]);
                        chk("resp_prod", bus.resp_prod, m_exp[15:0]);
                    end
                    rid_q.push_back(bus.resp_id);
                    resp_cnt++;
                    job_cyc = -1;
                end else begin
                    job_cyc++;
                end
            end else if (job_cyc >= 0) begin
                job_cyc++;
            end else if (m_eg != 2'b00) begin
                m_mand = m_g ? bus.req_mand1 : bus.req_mand0;
                m_mult = m_g ? bus.req_mult1 : bus.req_mult0;
                m_p    = int'($signed(m_mand)) * int'($signed(m_mult));
                sb.push_back({m_g, m_p[15:0]});
                cur_mand = m_mand;
                cur_mult = m_mult;
                tb_rr    = ~m_g;
                acc_cnt++;
                acc_by[m_g]++;
                job_cyc  = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [7:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 8'h80;
            1:       return 8'h7F;
            2:       return 8'h00;
            3:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic set_ops(input int r, input logic [7:0] m, input logic [7:0] n);
        if (r == 1) begin
            bus.req_mand1 = m; bus.req_mult1 = n;
        end else begin
            bus.req_mand0 = m; bus.req_mult0 = n;
        end
    endtask

    task automatic issue_job(input int r, input logic [7:0] m, input logic [7:0] n);
        int a0;
        int t;
        @(posedge Clk); #1;
        a0 = acc_by[r];
        set_ops(r, m, n);
        bus.req_valid[r] = 1'b1;
        t = 0;
        while (acc_by[r] == a0 && t < 100) begin
            @(posedge Clk); #1;
            t++;
        end
        bus.req_valid[r] = 1'b0;
        if (t >= 100) timeout_fail("issue_accept");
    endtask

    task automatic wait_resp(input int target);
        int t;
        t = 0;
        while (resp_cnt < target && t < 300) begin
            @(posedge Clk); #1;
            t++;
        end
        if (t >= 300) timeout_fail("wait_resp");
    endtask

    task automatic run_job(input int r, input logic [7:0] m, input logic [7:0] n);
        int r0;
        r0 = resp_cnt;
        issue_job(r, m, n);
        wait_resp(r0 + 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int t;
        int r0;
        int a0;
        int prev [2];

        bus.req_valid  = 2'b00;
        bus.req_mand0  = 8'h00;
        bus.req_mand1  = 8'h00;
        bus.req_mult0  = 8'h00;
        bus.req_mult1  = 8'h00;
        bus.resp_ready = 1'b1;

        repeat (3) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);

        // directed products, including full negative range and zero multiplier
        run_job(0, 8'h07, 8'h03);
        run_job(0, 8'hFE, 8'h03);
        run_job(0, 8'h80, 8'h80);
        run_job(0, 8'h7F, 8'h81);
        run_job(1, 8'h5A, 8'h00);

        // both requesters held valid: grants must alternate starting at 0
        rid_q.delete();
        r0 = resp_cnt;
        @(posedge Clk); #1;
        set_ops(0, rnd_op(), rnd_op());
        set_ops(1, rnd_op(), rnd_op());
        bus.req_valid = 2'b11;
        prev[0] = acc_by[0];
        prev[1] = acc_by[1];
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (acc_by[0] == prev[0] && acc_by[1] == prev[1] && t < 100) begin
                @(posedge Clk); #1;
                t++;
            end
            if (t >= 100) timeout_fail("arb_accept");
            for (int r = 0; r < 2; r++) begin
                if (acc_by[r] != prev[r]) begin
                    prev[r] = acc_by[r];
                    set_ops(r, rnd_op(), rnd_op());
                end
            end
        end
        bus.req_valid = 2'b00;
        wait_resp(r0 + 4);
        chk("arb_count", rid_q.size(), 4);
        if (rid_q.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("arb_order", rid_q[k], k % 2);
        end

        // backpressure: consumer stalls for 10 cycles while requester 1 waits
        bus.resp_ready = 1'b0;
        r0 = resp_cnt;
        issue_job(0, 8'hC3, 8'h5D);
        t = 0;
        while (!bus.resp_valid && t < 100) begin
            @(negedge Clk);
            t++;
        end
        if (t >= 100) timeout_fail("bp_resp_valid");
        @(posedge Clk); #1;
        set_ops(1, 8'h91, 8'h2B);
        bus.req_valid[1] = 1'b1;
        repeat (10) begin
            @(negedge Clk);
            chk("bp_busy",      bus.busy,       1);
            chk("bp_req_ready", bus.req_ready,  0);
            chk("bp_valid",     bus.resp_valid, 1);
        end
        @(posedge Clk); #1;
        bus.resp_ready = 1'b1;
        @(negedge Clk);
        chk("bp_hs_valid", bus.resp_valid, 1);
        @(negedge Clk);
        chk("bp_idle_next", bus.busy,      0);
        chk("bp_grant_r1",  bus.req_ready, 2'b10);
        @(posedge Clk); #1;
        bus.req_valid[1] = 1'b0;
        wait_resp(r0 + 2);

        // synchronous reset in the middle of a job abandons it
        issue_job(0, 8'h6B, 8'hB7);
        t = 0;
        while (job_cyc != 9 && t < 50) begin
            @(posedge Clk); #1;
            t++;
        end
        if (t >= 50) timeout_fail("reset_cycle9");
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        chk("mr_busy",     bus.busy,        0);
        chk("mr_clr_ld",   bus.dp_clr_ld,   0);
        chk("mr_clearA",   bus.dp_clearA,   0);
        chk("mr_addsub",   bus.dp_addsub,   0);
        chk("mr_sub_en",   bus.dp_sub_en,   0);
        chk("mr_shift_en", bus.dp_shift_en, 0);
        chk("mr_resp_val", bus.resp_valid,  0);
        run_job(1, 8'h80, 8'h7F);
        run_job(0, 8'hFF, 8'hFF);

        // randomized traffic: random valids, random drops, random backpressure
        prev[0] = acc_by[0];
        prev[1] = acc_by[1];
        a0 = acc_cnt;
        t  = 0;
        while ((acc_cnt - a0 < 24 || bus.req_valid != 2'b00 || job_cyc >= 0) && t < 4000) begin
            @(posedge Clk); #1;
            t++;
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 2; r++) begin
                if (acc_by[r] != prev[r]) begin
                    prev[r] = acc_by[r];
                    bus.req_valid[r] = 1'b0;
                end else if (bus.req_valid[r] && $urandom_range(0, 15) == 0) begin
                    bus.req_valid[r] = 1'b0;
                end else if (!bus.req_valid[r] && (acc_cnt - a0 < 24) && $urandom_range(0, 2) == 0) begin
                    set_ops(r, rnd_op(), rnd_op());
                    bus.req_valid[r] = 1'b1;
                end
            end
        end
        if (t >= 4000) timeout_fail("random_phase");
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mult_sched
`default_nettype wire
